rv_skid_buffer: RTL and testbench



---
 rtl/rv_pkg.sv | 13 +
 rtl/en_register.sv | 22 ++
 rtl/skid_buf_ctrl.sv | 50 +++++
 rtl/rv_skid_buffer.sv | 88 ++++++++
 tb/tb_rv_skid_buffer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared types for the ready/valid skid buffer: occupancy state encoding and depth.
// State bits are {skid_valid, main_valid}; 2'b10 cannot be reached.
package rv_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/en_register.sv
// Purpose: WIDTH-bit register with load enable, async clear to zero.
// Latency: d appears on q one clk after an enabled edge.
// Backpressure: none; en=0 holds the current value.
module en_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buf_ctrl.sv
// Purpose: next-state and register write-enable decode for the skid buffer.
// Latency: purely combinational.
// Backpressure: consumes fire_in/fire_out already qualified by the top.
module skid_buf_ctrl
  import rv_pkg::*;
(
  input  skid_state_t state,
  input  logic        fire_in,
  input  logic        fire_out,
  output skid_state_t next_state,
  output logic        main_we,
  output logic        main_sel_skid,
  output logic        skid_we
);

  always_comb begin
    next_state    = state;
    main_we       = 1'b0;
    main_sel_skid = 1'b0;
    skid_we       = 1'b0;
    case (state)
      EMPTY: begin
        if (fire_in) begin
          next_state = BUSY;
          main_we    = 1'b1;
        end
      end
      BUSY: begin
        if (fire_in && fire_out) begin
          main_we = 1'b1;
        end else if (fire_in) begin
          next_state = FULL;
          skid_we    = 1'b1;
        end else if (fire_out) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        // ready_in is low here, so only a drain can happen
        if (fire_out) begin
          next_state    = BUSY;
          main_we       = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

endmodule

// File: rtl/rv_skid_buffer.sv
// Purpose: two-entry registered ready/valid stage (main + skid); optional SKID_BUF_FLUSH_EN adds a sync flush.
// Latency: 1 clk from input accept to valid_out when not already holding data.
// Backpressure: ready_in = ~skid_valid, so one more beat is absorbed after ready_out drops.
module rv_skid_buffer
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_aL,
`ifdef SKID_BUF_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  skid_state_t           state;
  skid_state_t           state_d;
  skid_state_t           ctrl_next;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  fire_in;
  logic                  fire_out;
  logic                  main_we;
  logic                  main_sel_skid;
  logic                  skid_we;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_data;

  assign skid_valid = state[1];
  assign main_valid = state[0];

`ifdef SKID_BUF_FLUSH_EN
  // flush blocks both handshakes, so no write enable can fire this cycle
  assign ready_in  = ~skid_valid & ~flush;
  assign valid_out = main_valid & ~flush;
  assign state_d   = flush ? EMPTY : ctrl_next;
`else
  assign ready_in  = ~skid_valid;
  assign valid_out = main_valid;
  assign state_d   = ctrl_next;
`endif

  assign fire_in  = valid_in & ready_in;
  assign fire_out = valid_out & ready_out;

  skid_buf_ctrl u_ctrl (
    .state         (state),
    .fire_in       (fire_in),
    .fire_out      (fire_out),
    .next_state    (ctrl_next),
    .main_we       (main_we),
    .main_sel_skid (main_sel_skid),
    .skid_we       (skid_we)
  );

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  assign main_d = main_sel_skid ? skid_data : data_in;

  en_register #(.WIDTH(DATA_WIDTH)) u_main_reg (
    .clk    (clk),
    .rst_aL (rst_aL),
    .en     (main_we),
    .d      (main_d),
    .q      (data_out)
  );

  en_register #(.WIDTH(DATA_WIDTH)) u_skid_reg (
    .clk    (clk),
    .rst_aL (rst_aL),
    .en     (skid_we),
    .d      (data_in),
    .q      (skid_data)
  );

endmodule

// File: tb/tb_rv_skid_buffer.sv
// Scoreboard bench for rv_skid_buffer: accepted beats are queued, the monitor pops on each output transfer.
module tb_rv_skid_buffer;

  logic        clk;
  logic        rst_aL;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
  logic        flush_active;
`ifdef SKID_BUF_FLUSH_EN
  logic        flush;
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int illegal_seen = 0;
  logic [31:0] exp_q[$];

  rv_skid_buffer #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
`ifdef SKID_BUF_FLUSH_EN
    .flush     (flush),
`endif
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // input side: record every accepted beat
  initial forever begin
    @(negedge clk);
    if (rst_aL && valid_in && ready_in) exp_q.push_back(data_in);
  end

  // output side: every transfer must match the oldest accepted beat
  initial forever begin
    @(negedge clk);
    if (rst_aL) begin
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL scoreboard_underflow: got 0x%0h expected none at %0t", data_out, $time);
        end else begin
          check("data_out_seq", data_out, exp_q.pop_front());
        end
      end
      if (!ready_in && !valid_out && !flush_active) illegal_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_aL    = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
`ifdef SKID_BUF_FLUSH_EN
    flush     = 1'b0;
`endif
    #3;
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    #9 rst_aL = 1'b1;
    tick();

    // streaming at full rate
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 32'h11;
    tick();
    check("stream_valid_1", {31'd0, valid_out}, 32'd1);
    check("stream_data_1", data_out, 32'h11);
    data_in = 32'h22;
    tick();
    check("stream_data_2", data_out, 32'h22);
    check("stream_ready_2", {31'd0, ready_in}, 32'd1);
    data_in = 32'h33;
    tick();
    check("stream_data_3", data_out, 32'h33);
    check("stream_ready_3", {31'd0, ready_in}, 32'd1);
    valid_in = 1'b0;
    tick();
    check("stream_drained", {31'd0, valid_out}, 32'd0);

    // backpressure fills skid, then drains in order
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'hA;
    tick();
    check("bp_busy_data", data_out, 32'hA);
    data_in = 32'hB;
    tick();
    valid_in = 1'b0;
    check("bp_full_ready", {31'd0, ready_in}, 32'd0);
    check("bp_full_data", data_out, 32'hA);
    tick();
    check("bp_hold_data", data_out, 32'hA);
    check("bp_hold_valid", {31'd0, valid_out}, 32'd1);
    ready_out = 1'b1;
    tick();
    check("bp_pop1_data", data_out, 32'hB);
    check("bp_pop1_ready", {31'd0, ready_in}, 32'd1);
    tick();
    check("bp_pop2_valid", {31'd0, valid_out}, 32'd0);

    // simultaneous push and pop while BUSY
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h5;
    tick();
    check("sim_main_5", data_out, 32'h5);
    ready_out = 1'b1;
    data_in   = 32'h6;
    tick();
    valid_in = 1'b0;
    check("sim_data_6", data_out, 32'h6);
    check("sim_busy_ready", {31'd0, ready_in}, 32'd1);
    check("sim_busy_valid", {31'd0, valid_out}, 32'd1);
    tick();

    // async reset while FULL
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h77;
    tick();
    data_in = 32'h88;
    tick();
    valid_in = 1'b0;
    check("prerst_full_ready", {31'd0, ready_in}, 32'd0);
    #2 rst_aL = 1'b0;
    #1;
    check("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_ready_in", {31'd0, ready_in}, 32'd1);
    exp_q.delete();
    tick();
    rst_aL = 1'b1;
    tick();
    check("postrst_valid_out", {31'd0, valid_out}, 32'd0);

`ifdef SKID_BUF_FLUSH_EN
    valid_in = 1'b1;
    data_in  = 32'h1;
    tick();
    data_in = 32'h2;
    tick();
    valid_in = 1'b0;
    check("fl_full_ready", {31'd0, ready_in}, 32'd0);
    flush     = 1'b1;
    ready_out = 1'b1;
    #1;
    check("fl_cycle_valid", {31'd0, valid_out}, 32'd0);
    check("fl_cycle_ready", {31'd0, ready_in}, 32'd0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    #1;
    check("fl_after_valid", {31'd0, valid_out}, 32'd0);
    check("fl_after_ready", {31'd0, ready_in}, 32'd1);
    ready_out = 1'b0;
    tick();
`endif

    // random stalls on both sides
    for (int i = 0; i < 1000; i++) begin
      valid_in  = 1'($urandom_range(0, 1));
      ready_out = 1'($urandom_range(0, 1));
      data_in   = $urandom;
      tick();
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_valid_out", {31'd0, valid_out}, 32'd0);
    check("illegal_state_seen", illegal_seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
